// File: rtl/key_match_scanner.sv
// Sequential key search over an asynchronous-read memory: walks addresses
// 0..DEPTH-1, reports first-hit index and, in count mode, the number of hits.
module key_match_scanner #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              count_mode,
    input  logic [DATA_W-1:0] key,
    output logic [IDX_W-1:0]  mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [IDX_W-1:0]  match_idx,
    output logic [CNT_W-1:0]  match_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] key_q;
    logic              mode_q;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              last;

    assign hit  = (state == S_SCAN) && (mem_rdata == key_q);
    assign last = (idx == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_SCAN;
            S_SCAN: if ((hit && !mode_q) || last) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_SCAN);
        mem_rd_en = (state == S_SCAN);
        done      = (state == S_DONE);
        mem_addr  = (state == S_SCAN) ? idx : '0;
    end

    // Results are only touched on an accepted start or during SCAN, so they
    // hold from the done pulse until the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_q       <= '0;
            mode_q      <= 1'b0;
            idx         <= '0;
            found       <= 1'b0;
            match_idx   <= '0;
            match_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q       <= key;
                        mode_q      <= count_mode;
                        idx         <= '0;
                        found       <= 1'b0;
                        match_idx   <= '0;
                        match_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        match_count <= match_count + CNT_W'(1);
                        if (!found) begin
                            found     <= 1'b1;
                            match_idx <= idx;
                        end
                    end
                    if (!last && !(hit && !mode_q)) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_match_scanner.sv
// Scoreboard bench for key_match_scanner: stimulus pushes expected results,
// a negedge monitor compares them against each done pulse.
module tb_key_match_scanner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       count_mode;
    logic [7:0] key;
    logic [3:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] match_idx;
    logic [4:0] match_count;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    key_match_scanner #(
        .DATA_W(8),
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .count_mode (count_mode),
        .key        (key),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .match_idx  (match_idx),
        .match_count(match_count)
    );

    typedef struct {
        logic        f;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        int unsigned done_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned scan_start = 0;
    bit          scan_active = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: address walk while busy, and result comparison on done.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (busy) begin
                if (scan_active) check("mem_addr", mem_addr, cyc - scan_start - 1);
                check("rd_en_busy", mem_rd_en, 1);
            end else begin
                check("addr_idle", mem_addr, 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("found", found, e.f);
                    check("match_idx", match_idx, e.idx);
                    check("match_count", match_count, e.cnt);
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_in_done", busy, 0);
                end
                scan_active = 1'b0;
            end
        end
    end

    task automatic run_scan(input logic [7:0] k, input logic mode, input logic ef,
                            input logic [3:0] eidx, input logic [4:0] ecnt,
                            input int unsigned lat, input int pulse_at);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        key        = k;
        count_mode = mode;
        start      = 1'b1;
        scan_start = cyc;
        scan_active = 1'b1;
        e.f = ef; e.idx = eidx; e.cnt = ecnt; e.done_cyc = cyc + lat;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (pulse_at >= 0 && cyc == scan_start + pulse_at) begin
                start = 1'b1;
                key   = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_found", found, ef);
        check("hold_idx", match_idx, eidx);
        check("hold_count", match_count, ecnt);
    endtask

    task automatic mem_ramp();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        count_mode = 1'b0;
        key        = 8'h00;
        mem_ramp();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_idx", match_idx, 0);
        check("rst_count", match_count, 0);
        check("rst_rd_en", mem_rd_en, 0);
        reset_n = 1'b1;

        // First match at index 5.
        run_scan(8'h05, 1'b0, 1'b1, 4'd5, 5'd1, 7, -1);
        // Miss.
        run_scan(8'hA5, 1'b0, 1'b0, 4'd0, 5'd0, 17, -1);
        // Single hit in count mode still scans all entries.
        run_scan(8'h05, 1'b1, 1'b1, 4'd5, 5'd1, 17, -1);

        // Count mode with 14 hits.
        for (int i = 0; i < 16; i++) mem[i] = 8'h3C;
        mem[2]  = 8'h00;
        mem[15] = 8'h00;
        run_scan(8'h3C, 1'b1, 1'b1, 4'd0, 5'd14, 17, -1);

        // Last-entry hit, with an ignored start pulse mid-scan.
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[15] = 8'h7E;
        run_scan(8'h7E, 1'b0, 1'b1, 4'd15, 5'd1, 17, 5);

        // Reset mid-scan: no done, everything cleared.
        mem_ramp();
        @(posedge clk); #1;
        key        = 8'h0C;
        count_mode = 1'b0;
        start      = 1'b1;
        scan_start = cyc;
        scan_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        scan_active = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_found", found, 0);
        check("abort_count", match_count, 0);
        check("abort_rd_en", mem_rd_en, 0);
        reset_n = 1'b1;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_abort_busy", busy, 0);

        run_scan(8'h0C, 1'b0, 1'b1, 4'd12, 5'd1, 14, -1);

        repeat (2) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_match_scanner.md
Name: key_match_scanner

Overview:
- Sequential initiator that issues 8-bit equality comparisons against a small asynchronous-read data memory.
- On `start` it walks addresses 0..DEPTH-1, one per cycle, and compares each read word with a latched key.
- Reports whether the key was found, the index of the first hit and, in count mode, the total number of hits.
- Sits beside the datapath memory as a search/lookup helper and reuses the team's equality-compare convention: equal = bitwise identical.

Parameters:
- DATA_W, 8, width of key and memory words.
- DEPTH, 16, number of memory entries scanned (>=2).
- IDX_W, $clog2(DEPTH), address/index width (derived, not overridden).
- CNT_W, $clog2(DEPTH+1), match counter width (derived).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request a scan; accepted only in IDLE.
- count_mode  input  1  0 = stop at first match; 1 = scan all entries and count; sampled with start.
- key  input  DATA_W  search value; sampled with start.
- mem_addr  output  IDX_W  read address to memory.
- mem_rd_en  output  1  high while scanning.
- mem_rdata  input  DATA_W  combinational read data for mem_addr, valid the same cycle.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle completion pulse.
- found  output  1  at least one match in the last scan.
- match_idx  output  IDX_W  index of the first match; 0 if none.
- match_count  output  CNT_W  number of matches; count_mode=0 gives 1 if found, else 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
- Reset: state=IDLE. mem_addr, mem_rd_en, busy, done, found, match_idx and match_count all go to 0. Key and mode registers clear.
- States: IDLE, SCAN, DONE.
- IDLE, start=1: latch key into key_q and count_mode into mode_q; clear found, match_idx, match_count; set idx=0; go to SCAN.
- IDLE, start=0: hold all results from the previous scan.
- SCAN: mem_addr=idx, mem_rd_en=1, busy=1. hit = (mem_rdata == key_q), exact equality over all DATA_W bits.
- On a hit with found=0: set found=1, match_idx=idx.
- On a hit: match_count += 1 (saturation impossible by construction of CNT_W).
- mode_q=0 and hit: go to DONE.
- Otherwise, idx==DEPTH-1: go to DONE.
- Otherwise: idx += 1. idx never wraps.
- DONE: done=1 for exactly one cycle, busy=0, mem_rd_en=0; go to IDLE.
- Latency, start sampled at edge 0:
  - First-match hit at index i: done high during cycle i+2.
  - Miss, or any count_mode scan: done high during cycle DEPTH+1.
- Result validity: results are stable from the done cycle until the next accepted start.
- start while busy or during DONE: ignored. No queuing, and key/mode changes have no effect.
- mem_addr outside SCAN: holds 0.
- Hit on last entry (idx=DEPTH-1): recorded, then DONE. Same timing as a miss in count mode.
- reset_n=0 mid-scan: abort immediately to IDLE, all outputs 0 next cycle, no done pulse.
- start and reset_n=0 in the same cycle: reset wins.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> busy=done=found=0, match_idx=0, match_count=0, mem_rd_en=0.
- First-match: mem = {0x00..0x0F}, key=0x05, count_mode=0, start at cycle 0 -> mem_addr sequence 0..5, done at cycle 7, found=1, match_idx=5, match_count=1.
- Miss: same mem, key=0xA5 -> 16 SCAN cycles, done at cycle 17, found=0, match_idx=0, match_count=0.
- Count: mem all 0x3C except idx 2 and 15 = 0x00, key=0x3C, count_mode=1 -> done at cycle 17, found=1, match_idx=0, match_count=14.
- Boundary: only mem[15]=0x7E, key=0x7E, count_mode=0 -> done at cycle 17, match_idx=15. Pulse start with key=0x00 at cycle 5 -> no effect on results.
- Reset mid-scan: assert reset_n=0 at cycle 4 -> next cycle IDLE, no done pulse. A new start then completes normally with correct results.
